// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared constants and width helpers for shift_reg_param
package shift_reg_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // fill must hold the value DEPTH itself, so it needs one bit more than the tap address
  function automatic int fill_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// rtl/shift_reg_stage.sv - one WIDTH-bit stage with clear/load/shift/hold next-value mux
// Load inputs exist only when SHIFT_REG_PLOAD_EN is defined.
module shift_reg_stage
  import shift_reg_pkg::*;
#(
  parameter int              WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sclr,
`ifdef SHIFT_REG_PLOAD_EN
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pdata,
`endif
  input  logic             i_ce,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_from_lo,
  input  logic [WIDTH-1:0] i_from_hi,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_q;
    if (i_sclr) begin
      w_next = INIT;
    end
`ifdef SHIFT_REG_PLOAD_EN
    else if (i_load) begin
      w_next = i_pdata;
    end
`endif
    else if (i_ce) begin
      w_next = (i_dir == DIR_DOWN) ? i_from_hi : i_from_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= INIT;
    else        r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - parametrised bidirectional shift register with tap, fill count and
// optional parallel load (SHIFT_REG_PLOAD_EN)
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   dir,
  input  logic                   sclr,
  input  logic [WIDTH-1:0]       si,
  input  logic [AW-1:0]          addr,
`ifdef SHIFT_REG_PLOAD_EN
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] pdata,
`endif
  output logic [WIDTH-1:0]       so,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [AW:0]            fill,
  output logic                   full
);

  localparam int            FW       = fill_width(AW);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH-1:0] w_stage [DEPTH];
  logic [FW-1:0]    r_fill;
  logic [WIDTH-1:0] w_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_from_lo;
    logic [WIDTH-1:0] w_from_hi;

    // End stages take serial input from whichever side the data is entering
    if (g == 0) begin : g_lo_si
      assign w_from_lo = si;
    end else begin : g_lo_nb
      assign w_from_lo = w_stage[g-1];
    end
    if (g == DEPTH - 1) begin : g_hi_si
      assign w_from_hi = si;
    end else begin : g_hi_nb
      assign w_from_hi = w_stage[g+1];
    end

    shift_reg_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sclr    (sclr),
`ifdef SHIFT_REG_PLOAD_EN
      .i_load    (load),
      .i_pdata   (pdata[g*WIDTH +: WIDTH]),
`endif
      .i_ce      (ce),
      .i_dir     (dir),
      .i_from_lo (w_from_lo),
      .i_from_hi (w_from_hi),
      .o_q       (w_stage[g])
    );

    assign pout[g*WIDTH +: WIDTH] = w_stage[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (sclr) begin
      r_fill <= '0;
    end
`ifdef SHIFT_REG_PLOAD_EN
    else if (load) begin
      r_fill <= FILL_MAX;
    end
`endif
    else if (ce && (r_fill != FILL_MAX)) begin
      r_fill <= r_fill + FW'(1);
    end
  end

  // Out-of-range tap addresses read as zero
  always_comb begin
    w_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) w_q = w_stage[i];
    end
  end

  assign q    = w_q;
  assign so   = (dir == DIR_DOWN) ? w_stage[0] : w_stage[DEPTH-1];
  assign fill = r_fill;
  assign full = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_shift_reg_param.sv
// tb/tb_shift_reg_param.sv - self-checking bench for shift_reg_param, three instances, queue model
module tb_shift_reg_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dir = 1'b0, sclr = 1'b0, load = 1'b0;
  logic ce3 = 1'b0, ce4 = 1'b0, ce5 = 1'b0;
  logic        si3 = '0;
  logic [7:0]  si4 = '0, si5 = '0;
  logic [1:0]  addr3 = '0, addr4 = '0;
  logic [2:0]  addr5 = '0;
  logic [2:0]  pdata3 = '0;
  logic [31:0] pdata4 = '0;
  logic [39:0] pdata5 = '0;

  logic        so3, q3;
  logic [2:0]  pout3;
  logic [2:0]  fill3;
  logic        full3;
  logic [7:0]  so4, q4, so5, q5;
  logic [31:0] pout4;
  logic [39:0] pout5;
  logic [2:0]  fill4;
  logic [3:0]  fill5;
  logic        full4, full5;

  always #5 clk = ~clk;

  shift_reg_param #(.WIDTH(1), .DEPTH(3), .INIT(1'b0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .ce(ce3), .dir(dir), .sclr(sclr), .si(si3), .addr(addr3),
`ifdef SHIFT_REG_PLOAD_EN
    .load(load), .pdata(pdata3),
`endif
    .so(so3), .q(q3), .pout(pout3), .fill(fill3), .full(full3));

  shift_reg_param #(.WIDTH(8), .DEPTH(4), .INIT(8'h5A)) u_d4 (
    .clk(clk), .rst_n(rst_n), .ce(ce4), .dir(dir), .sclr(sclr), .si(si4), .addr(addr4),
`ifdef SHIFT_REG_PLOAD_EN
    .load(load), .pdata(pdata4),
`endif
    .so(so4), .q(q4), .pout(pout4), .fill(fill4), .full(full4));

  shift_reg_param #(.WIDTH(8), .DEPTH(5), .INIT(8'h3C)) u_d5 (
    .clk(clk), .rst_n(rst_n), .ce(ce5), .dir(dir), .sclr(sclr), .si(si5), .addr(addr5),
`ifdef SHIFT_REG_PLOAD_EN
    .load(load), .pdata(pdata5),
`endif
    .so(so5), .q(q5), .pout(pout5), .fill(fill5), .full(full5));

  logic [63:0] o_so [3], o_q [3], o_pout [3], o_fill [3], o_full [3];
  assign o_so[0] = 64'(so3);   assign o_so[1] = 64'(so4);   assign o_so[2] = 64'(so5);
  assign o_q[0]  = 64'(q3);    assign o_q[1]  = 64'(q4);    assign o_q[2]  = 64'(q5);
  assign o_pout[0] = 64'(pout3); assign o_pout[1] = 64'(pout4); assign o_pout[2] = 64'(pout5);
  assign o_fill[0] = 64'(fill3); assign o_fill[1] = 64'(fill4); assign o_fill[2] = 64'(fill5);
  assign o_full[0] = 64'(full3); assign o_full[1] = 64'(full4); assign o_full[2] = 64'(full5);

  // Reference model: each chain is a queue, element i = stage i
  int         dep [3] = '{3, 4, 5};
  int         wid [3] = '{1, 8, 8};
  logic [7:0] ini [3] = '{8'h00, 8'h5A, 8'h3C};
  logic [7:0] mq [3][$];
  int         mf [3];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      for (int i = 0; i < dep[k]; i++) mq[k].push_back(ini[k]);
      mf[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [7:0]  sin;
    logic [63:0] pd;
    logic        cek;
    logic [7:0]  msk;
    for (int k = 0; k < 3; k++) begin
      sin = (k == 0) ? 8'(si3) : (k == 1) ? si4 : si5;
      pd  = (k == 0) ? 64'(pdata3) : (k == 1) ? 64'(pdata4) : 64'(pdata5);
      cek = (k == 0) ? ce3 : (k == 1) ? ce4 : ce5;
      msk = (wid[k] == 8) ? 8'hFF : 8'h01;
      if (sclr) begin
        foreach (mq[k][i]) mq[k][i] = ini[k];
        mf[k] = 0;
      end
`ifdef SHIFT_REG_PLOAD_EN
      else if (load) begin
        for (int i = 0; i < dep[k]; i++) mq[k][i] = 8'(pd >> (i * wid[k])) & msk;
        mf[k] = dep[k];
      end
`endif
      else if (cek) begin
        if (!dir) begin
          mq[k].push_front(sin);
          void'(mq[k].pop_back());
        end else begin
          mq[k].push_back(sin);
          void'(mq[k].pop_front());
        end
        if (mf[k] < dep[k]) mf[k]++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int          a;
    logic [63:0] ep;
    for (int k = 0; k < 3; k++) begin
      a  = (k == 0) ? int'(addr3) : (k == 1) ? int'(addr4) : int'(addr5);
      ep = '0;
      for (int i = 0; i < dep[k]; i++) ep |= 64'(mq[k][i]) << (i * wid[k]);
      chk($sformatf("%s.d%0d.pout", tag, dep[k]), o_pout[k], ep);
      chk($sformatf("%s.d%0d.so", tag, dep[k]), o_so[k],
          64'(dir ? mq[k][0] : mq[k][dep[k]-1]));
      chk($sformatf("%s.d%0d.q", tag, dep[k]), o_q[k], (a < dep[k]) ? 64'(mq[k][a]) : 64'd0);
      chk($sformatf("%s.d%0d.fill", tag, dep[k]), o_fill[k], 64'(mf[k]));
      chk($sformatf("%s.d%0d.full", tag, dep[k]), o_full[k], 64'(mf[k] == dep[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    chk("rst.pout3", o_pout[0], 64'h0);
    chk("rst.pout4", o_pout[1], 64'h5A5A5A5A);
    chk("rst.pout5", o_pout[2], 64'h3C3C3C3C3C);
    chk("rst.fill4", o_fill[1], 64'h0);
    check_model("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Serial fill on all chains: d3 gets 1,0,1,0; d4 0x11..0x44; d5 0x01..0x04
    dir = 1'b0; ce3 = 1'b1; ce4 = 1'b1; ce5 = 1'b1;
    si3 = 1'b1; si4 = 8'h11; si5 = 8'h01; tick();
    si3 = 1'b0; si4 = 8'h22; si5 = 8'h02; tick();
    si3 = 1'b1; si4 = 8'h33; si5 = 8'h03; tick();
    chk("fill3.pout", o_pout[0], 64'b101);
    chk("fill3.so", o_so[0], 64'd1);
    chk("fill3.fill", o_fill[0], 64'd3);
    chk("fill3.full", o_full[0], 64'd1);
    si3 = 1'b0; si4 = 8'h44; si5 = 8'h04; tick();
    chk("fill3.so4", o_so[0], 64'd0);
    chk("fill3.sat", o_fill[0], 64'd3);
    check_model("fill");

    ce3 = 1'b0; ce4 = 1'b0; si5 = 8'h05; tick();
    ce5 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      addr5 = 3'(a); #1;
      chk($sformatf("tap.a%0d", a), o_q[2], (a < 5) ? 64'(5 - a) : 64'd0);
    end

    for (int c = 0; c < 5; c++) begin
      si4 = 8'($urandom); tick();
      chk($sformatf("hold.c%0d", c), o_pout[1], 64'h11223344);
    end
    dir = 1'b1; ce4 = 1'b1; si4 = 8'hAA; tick();
    chk("dir.pout4", o_pout[1], 64'hAA112233);
    chk("dir.so4", o_so[1], 64'h33);
    check_model("dir");

`ifdef SHIFT_REG_PLOAD_EN
    load = 1'b1; pdata4 = 32'h44332211; pdata3 = 3'($urandom); pdata5 = 40'h0504030201;
    tick();
    chk("load.pout4", o_pout[1], 64'h44332211);
    chk("load.fill4", o_fill[1], 64'd4);
    sclr = 1'b1; tick();
    chk("sclr.pout4", o_pout[1], 64'h5A5A5A5A);
    chk("sclr.fill4", o_fill[1], 64'd0);
    sclr = 1'b0; load = 1'b0;
    check_model("load");
`endif

    // Async reset between edges while shifting
    dir = 1'b0; ce3 = 1'b1; ce4 = 1'b1; ce5 = 1'b1; si3 = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0; #1;
    model_reset();
    chk("arst.pout4", o_pout[1], 64'h5A5A5A5A);
    chk("arst.fill5", o_fill[2], 64'd0);
    check_model("arst");
    @(posedge clk); #1;
    check_model("arst_hold");
    rst_n = 1'b1;
    tick(); tick();
    chk("relat.so3_2", o_so[0], 64'd0);
    tick();
    chk("relat.so3_3", o_so[0], 64'd1);
    check_model("relat");

    // Randomised traffic, also re-checking after mid-cycle dir/addr changes
    for (int n = 0; n < 400; n++) begin
      ce3 = ($urandom_range(0, 3) != 0);
      ce4 = ($urandom_range(0, 3) != 0);
      ce5 = ($urandom_range(0, 3) != 0);
      dir = ($urandom_range(0, 3) == 0);
      sclr = ($urandom_range(0, 19) == 0);
`ifdef SHIFT_REG_PLOAD_EN
      load = ($urandom_range(0, 19) == 0);
`endif
      si3 = 1'($urandom); si4 = 8'($urandom); si5 = 8'($urandom);
      pdata3 = 3'($urandom); pdata4 = 32'($urandom);
      pdata5 = {8'($urandom), 32'($urandom)};
      addr3 = 2'($urandom); addr4 = 2'($urandom); addr5 = 3'($urandom);
      tick();
      check_model($sformatf("rnd%0d", n));
      if ((n % 8) == 0) begin
        dir = ~dir; addr3 = 2'($urandom); addr5 = 3'($urandom); #1;
        check_model($sformatf("rndc%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
